// File: rtl/mux2_8_arbiter.sv
// Round-robin arbiter for two 8-bit requesters that share one datapath.
// Owns the select of the shared mux2_8 and registers the chosen beat into
// a 1-deep valid/ready output stage. Locked bursts are capped at MAX_BURST.

// 8-bit 2:1 multiplexer shared between the two requesters.
module mux2_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       sel,
  output logic [7:0] y
);

  // Pure combinational select: sel=0 passes a, sel=1 passes b.
  always_comb begin
    y = sel ? b : a;
  end

endmodule

module mux2_8_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             lock0,
  input  logic [WIDTH-1:0] data0,
  output logic             gnt0,
  input  logic             req1,
  input  logic             lock1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt1,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic             sel,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  state_t     state;
  logic       last;
  logic [3:0] beat_cnt;
  logic [3:0] beat_nxt;
  logic       slot_free;
  logic       burst_more;
  logic [7:0] mux_y;

  mux2_8 u_mux (
    .a   (data0),
    .b   (data1),
    .sel (sel),
    .y   (mux_y)
  );

  // Grant decode: owner gets a beat only when it still requests and the
  // output register can take a new value. Gated by rst so that no beat is
  // accepted in the cycle a reset is applied mid-burst.
  always_comb begin
    beat_nxt   = beat_cnt + 4'd1;
    burst_more = (beat_nxt < MAX_B);
    slot_free  = !out_valid || out_ready;
    gnt0       = !rst && (state == OWN0) && req0 && slot_free;
    gnt1       = !rst && (state == OWN1) && req1 && slot_free;
  end

  // Arbitration FSM with registered sel/busy that track the owner state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel      <= 1'b0;
      busy     <= 1'b0;
      last     <= 1'b1;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Tie goes to the requester that did not own the bus last.
          if (req0 && (!req1 || last)) begin
            state    <= OWN0;
            sel      <= 1'b0;
            busy     <= 1'b1;
            last     <= 1'b0;
            beat_cnt <= '0;
          end else if (req1) begin
            state    <= OWN1;
            sel      <= 1'b1;
            busy     <= 1'b1;
            last     <= 1'b1;
            beat_cnt <= '0;
          end
        end
        OWN0: begin
          if (!req0) begin
            state <= IDLE;
            sel   <= 1'b0;
            busy  <= 1'b0;
          end else if (gnt0) begin
            beat_cnt <= beat_nxt;
            if (!(lock0 && burst_more)) begin
              state <= IDLE;
              sel   <= 1'b0;
              busy  <= 1'b0;
            end
          end
        end
        OWN1: begin
          if (!req1) begin
            state <= IDLE;
            sel   <= 1'b0;
            busy  <= 1'b0;
          end else if (gnt1) begin
            beat_cnt <= beat_nxt;
            if (!(lock1 && burst_more)) begin
              state <= IDLE;
              sel   <= 1'b0;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          sel   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Output register: a grant loads a new beat (replacing one consumed in
  // the same cycle); a consume with no grant empties the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
    end else if (gnt0 || gnt1) begin
      out_valid <= 1'b1;
      out_data  <= mux_y;
      out_src   <= gnt1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) !(gnt0 && gnt1));
  a_gnt0_req:   assert property (@(posedge clk) disable iff (rst) gnt0 |-> req0);
  a_gnt1_req:   assert property (@(posedge clk) disable iff (rst) gnt1 |-> req1);
  a_cnt_bound:  assert property (@(posedge clk) disable iff (rst) beat_cnt <= MAX_B);

endmodule

// File: tb/tb_mux2_8_arbiter.sv
// Directed bench for mux2_8_arbiter: stimulus pushes hand-computed beats
// into a scoreboard queue; a monitor pops them as the consumer accepts.
module tb_mux2_8_arbiter;

  typedef struct packed {
    logic       src;
    logic [7:0] data;
  } beat_t;

  logic       clk;
  logic       rst;
  logic       req0, lock0, gnt0;
  logic       req1, lock1, gnt1;
  logic [7:0] data0, data1;
  logic       out_valid, out_src, out_ready;
  logic [7:0] out_data;
  logic       sel, busy;

  int checks   = 0;
  int failures = 0;
  beat_t exp_q[$];

  mux2_8_arbiter #(.WIDTH(8), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .lock0     (lock0),
    .data0     (data0),
    .gnt0      (gnt0),
    .req1      (req1),
    .lock1     (lock1),
    .data1     (data1),
    .gnt1      (gnt1),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp_v, $time);
    end
  endtask

  // One cycle: check combinational grants and registered sel/busy mid-cycle,
  // then advance to just after the next rising edge.
  task automatic cyc(input string name, input logic g0, input logic g1,
                     input logic b, input logic s);
    @(negedge clk);
    chk1({name, ".gnt0"}, gnt0, g0);
    chk1({name, ".gnt1"}, gnt1, g1);
    chk1({name, ".busy"}, busy, b);
    chk1({name, ".sel"},  sel,  s);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    lock0 = 1'b0;
    lock1 = 1'b0;
    data0 = 8'h00;
    data1 = 8'h00;
    out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  task automatic push(input logic src, input logic [7:0] d);
    beat_t b;
    b.src  = src;
    b.data = d;
    exp_q.push_back(b);
  endtask

  // Monitor: every accepted output beat must match the queue head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got src=%b data=%02h expected no beat at %0t",
                 out_src, out_data, $time);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        chk1("sb_src",  out_src,  e.src);
        chk8("sb_data", out_data, e.data);
      end
    end
  end

  initial begin
    repeat (3000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and single request latency.
    do_reset();
    chk1("rst.out_valid", out_valid, 1'b0);
    chk8("rst.out_data",  out_data,  8'h00);
    chk1("rst.out_src",   out_src,   1'b0);
    req0 = 1'b1; data0 = 8'hA5; push(1'b0, 8'hA5);
    cyc("t1.c0", 0, 0, 0, 0);
    cyc("t1.c1", 1, 0, 1, 0);
    chk1("t1.out_valid", out_valid, 1'b1);
    chk8("t1.out_data",  out_data,  8'hA5);
    req0 = 1'b0;
    cyc("t1.c2", 0, 0, 0, 0);
    cyc("t1.c3", 0, 0, 0, 0);
    chk1("t1.drained", out_valid, 1'b0);

    // Tie: round-robin 0,1,0,1 with an IDLE bubble between tenures.
    do_reset();
    req0 = 1'b1; req1 = 1'b1; data0 = 8'h30; data1 = 8'h40;
    push(1'b0, 8'h30); push(1'b1, 8'h40); push(1'b0, 8'h31); push(1'b1, 8'h41);
    for (int unsigned k = 0; k < 2; k++) begin
      cyc("t2.idle_a", 0, 0, 0, 0);
      cyc("t2.gnt0",   1, 0, 1, 0);
      data0 = 8'h31;
      cyc("t2.idle_b", 0, 0, 0, 0);
      cyc("t2.gnt1",   0, 1, 1, 1);
      data1 = 8'h41;
    end
    req0 = 1'b0; req1 = 1'b0;
    cyc("t2.end0", 0, 0, 0, 0);
    cyc("t2.end1", 0, 0, 0, 0);

    // Locked burst capped at 4 beats, then the other requester gets a turn.
    do_reset();
    req0 = 1'b1; lock0 = 1'b1; data0 = 8'h01;
    req1 = 1'b1; lock1 = 1'b0; data1 = 8'hB1;
    push(1'b0, 8'h01); push(1'b0, 8'h02); push(1'b0, 8'h03); push(1'b0, 8'h04);
    push(1'b1, 8'hB1); push(1'b0, 8'h05); push(1'b0, 8'h06);
    cyc("t3.idle0", 0, 0, 0, 0);
    for (int unsigned k = 0; k < 4; k++) begin
      cyc("t3.burst", 1, 0, 1, 0);
      data0 = data0 + 8'h01;
    end
    cyc("t3.idle1", 0, 0, 0, 0);
    cyc("t3.gnt1",  0, 1, 1, 1);
    req1 = 1'b0;
    cyc("t3.idle2", 0, 0, 0, 0);
    cyc("t3.gnt05", 1, 0, 1, 0);
    data0 = 8'h06; lock0 = 1'b0;
    cyc("t3.gnt06", 1, 0, 1, 0);
    req0 = 1'b0;
    cyc("t3.end0", 0, 0, 0, 0);
    cyc("t3.end1", 0, 0, 0, 0);

    // Backpressure stall in OWN1, then grant in the ready cycle.
    do_reset();
    out_ready = 1'b0;
    req1 = 1'b1; lock1 = 1'b1; data1 = 8'h61;
    push(1'b1, 8'h61); push(1'b1, 8'h62);
    cyc("t4.idle", 0, 0, 0, 0);
    cyc("t4.gnt1", 0, 1, 1, 1);
    data1 = 8'h62;
    for (int unsigned k = 0; k < 3; k++) begin
      chk1("t4.stall_valid", out_valid, 1'b1);
      chk8("t4.stall_data",  out_data,  8'h61);
      cyc("t4.stall", 0, 0, 1, 1);
    end
    out_ready = 1'b1;
    cyc("t4.release", 0, 1, 1, 1);
    chk1("t4.kept_valid", out_valid, 1'b1);
    chk8("t4.new_data",   out_data,  8'h62);
    req1 = 1'b0; lock1 = 1'b0;
    cyc("t4.abandon", 0, 0, 1, 1);
    cyc("t4.end", 0, 0, 0, 0);

    // Abandon: enter OWN0 while the slot is full, drop req0, tie then goes to 1.
    do_reset();
    out_ready = 1'b0;
    req1 = 1'b1; data1 = 8'h71;
    push(1'b1, 8'h71); push(1'b1, 8'h72); push(1'b0, 8'h81);
    cyc("t5.idle0", 0, 0, 0, 0);
    cyc("t5.gnt71", 0, 1, 1, 1);
    req1 = 1'b0; req0 = 1'b1; data0 = 8'h81;
    cyc("t5.idle1", 0, 0, 0, 0);
    cyc("t5.own0_full", 0, 0, 1, 0);
    req0 = 1'b0;
    cyc("t5.drop", 0, 0, 1, 0);
    req0 = 1'b1; req1 = 1'b1; data1 = 8'h72; out_ready = 1'b1;
    cyc("t5.idle2", 0, 0, 0, 0);
    cyc("t5.gnt72", 0, 1, 1, 1);
    req1 = 1'b0;
    cyc("t5.idle3", 0, 0, 0, 0);
    cyc("t5.gnt81", 1, 0, 1, 0);
    req0 = 1'b0;
    cyc("t5.end0", 0, 0, 0, 0);
    cyc("t5.end1", 0, 0, 0, 0);

    // Reset during a locked burst drops the held beat and issues no grant.
    do_reset();
    req0 = 1'b1; lock0 = 1'b1; data0 = 8'h91;
    push(1'b0, 8'h91);
    cyc("t6.idle", 0, 0, 0, 0);
    cyc("t6.gnt91", 1, 0, 1, 0);
    data0 = 8'h92;
    cyc("t6.gnt92", 1, 0, 1, 0);
    data0 = 8'h93;
    chk1("t6.pre_valid", out_valid, 1'b1);
    chk8("t6.pre_data",  out_data,  8'h92);
    rst = 1'b1;
    cyc("t6.rst_cycle", 0, 0, 1, 0);
    rst = 1'b0; req0 = 1'b0; lock0 = 1'b0;
    chk1("t6.out_valid", out_valid, 1'b0);
    chk8("t6.out_data",  out_data,  8'h00);
    chk1("t6.out_src",   out_src,   1'b0);
    cyc("t6.after0", 0, 0, 0, 0);
    cyc("t6.after1", 0, 0, 0, 0);

    chk8("sb_empty", 8'(exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
